// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared state encoding, register map and CTRL bit positions
// for the LED pattern sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD, S_DONE} state_e;

    localparam logic [31:0] LED_ADDR    = 32'hFFFF_0010;
    localparam logic [31:0] CTRL_ADDR   = 32'hFFFF_0020;
    localparam logic [31:0] PERIOD_ADDR = 32'hFFFF_0024;
    localparam logic [31:0] LEN_ADDR    = 32'hFFFF_0028;
    localparam logic [31:0] STATUS_ADDR = 32'hFFFF_002C;
    localparam logic [31:0] PAT_BASE    = 32'hFFFF_0030;

    localparam int CTRL_START = 0;
    localparam int CTRL_LOOP  = 1;
    localparam int CTRL_STOP  = 2;
    localparam int CTRL_CLR   = 3;

    // Run length latched at START: 0 means one step, oversize means all slots.
    function automatic logic [3:0] clamp_len(input logic [31:0] len, input int unsigned n);
        return (len == 32'd0) ? 4'd1 : ((len > 32'(n)) ? 4'(n) : len[3:0]);
    endfunction

endpackage

// File: rtl/led_seq_timer.sv
// led_seq_timer: step-period counter with clear, enable and terminal-count
// flag; a period of 0 behaves as 1.
module led_seq_timer
    import led_seq_pkg::*;
#(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] period_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last_cnt;

    assign last_cnt = (period_i > CNT_W'(1)) ? period_i - CNT_W'(1) : '0;
    // >= keeps a period shortened mid-step from running the counter to wrap.
    assign tc_o     = en_i && (cnt_q >= last_cnt);

    always_comb cnt_d = clr_i ? '0 : (en_i ? cnt_q + CNT_W'(1) : cnt_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/led_seq.sv
// led_seq: memory-mapped LED pattern sequencer writing PAT slots to the LED
// register. Optional irq and sticky done flag enabled by LED_SEQ_IRQ_EN.
module led_seq
    import led_seq_pkg::*;
#(
    parameter int NUM_PAT = 4,
    parameter int CNT_W   = 24
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        led_we,
    output logic [31:0] led_addr,
    output logic [31:0] led_din
`ifdef LED_SEQ_IRQ_EN
    ,
    output logic        irq
`endif
);

    state_e           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic             loop_q, loop_d;
    logic [3:0]       run_len_q, run_len_d;
    logic [CNT_W-1:0] period_q;
    logic [31:0]      len_q;
    logic [7:0]       pat_q [8];
    logic [31:0]      pat_off, status;
    logic             cpu_led, ctrl_wr, start, stop, pat_wr, seq_we, last, tc, done_bit;

    assign cpu_led = we && (addr == LED_ADDR);
    assign ctrl_wr = we && (addr == CTRL_ADDR);
    assign start   = ctrl_wr && din[CTRL_START];
    assign stop    = ctrl_wr && din[CTRL_STOP];
    assign pat_off = addr - PAT_BASE;
    assign pat_wr  = we && (pat_off[1:0] == 2'd0) && (pat_off < 32'(4 * NUM_PAT));
    // A CPU store to the LED register wins; the sequencer retries next cycle.
    assign seq_we  = (state_q == S_LOAD) && !cpu_led && !stop;
    assign last    = ({1'b0, idx_q} == run_len_q - 4'd1);

    led_seq_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rstn     (rstn),
        .clr_i    (seq_we),
        .en_i     (state_q == S_HOLD),
        .period_i (period_q),
        .tc_o     (tc)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            period_q <= CNT_W'(1);
            len_q    <= 32'd1;
            for (int i = 0; i < 8; i++) pat_q[i] <= '0;
        end else begin
            if (we && addr == PERIOD_ADDR) period_q <= din[CNT_W-1:0];
            if (we && addr == LEN_ADDR)    len_q    <= din;
            if (pat_wr)                    pat_q[pat_off[4:2]] <= din[7:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        loop_d    = loop_q;
        run_len_d = run_len_q;
        if (stop) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: if (start) begin
                    state_d   = S_LOAD;
                    idx_d     = 3'd0;
                    loop_d    = din[CTRL_LOOP];
                    run_len_d = clamp_len(len_q, NUM_PAT);
                end
                S_LOAD: state_d = seq_we ? S_HOLD : S_LOAD;
                S_HOLD: if (tc) begin
                    state_d = (last && !loop_q) ? S_DONE : S_LOAD;
                    idx_d   = (last && !loop_q) ? idx_q : (last ? 3'd0 : idx_q + 3'd1);
                end
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            loop_q    <= 1'b0;
            run_len_q <= 4'd1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            loop_q    <= loop_d;
            run_len_q <= run_len_d;
        end
    end

`ifdef LED_SEQ_IRQ_EN
    logic done_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) done_q <= 1'b0;
        else       done_q <= (state_q == S_DONE) || (done_q && !(ctrl_wr && din[CTRL_CLR]));
    end
    assign irq      = (state_q == S_DONE) || ((state_q == S_HOLD) && tc && last && loop_q && !stop);
    assign done_bit = done_q;
`else
    assign done_bit = 1'b0;
`endif

    assign status = {21'd0, idx_q, 6'd0, done_bit, state_q != S_IDLE};

    // Outputs are gated by rstn so they fall to zero the moment reset asserts.
    assign led_we   = rstn && (cpu_led || seq_we);
    assign led_addr = led_we ? LED_ADDR : 32'd0;
    assign led_din  = !rstn ? 32'd0 : (cpu_led ? din : (seq_we ? {24'd0, pat_q[idx_q]} : 32'd0));
    assign dout     = !rstn ? 32'd0 :
                      (addr == STATUS_ADDR) ? status :
                      (addr == PERIOD_ADDR) ? 32'(period_q) :
                      (addr == LEN_ADDR)    ? len_q : 32'd0;

endmodule

// File: doc/led_seq.md
LED_SEQ -- requirements
Module: led_seq

Interface
REQ-001 SHALL have parameter NUM_PAT, default 4, number of pattern slots (2..8).
REQ-002 SHALL have parameter CNT_W, default 24, width of the step-period counter.
REQ-003 SHALL have port clk, input, 1, single system clock; all state on posedge clk.
REQ-004 SHALL have port rstn, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port we, input, 1, CPU store strobe.
REQ-006 SHALL have port addr, input, 32, CPU byte address.
REQ-007 SHALL have port din, input, 32, CPU store data.
REQ-008 SHALL have port dout, output, 32, combinational read data for STATUS/PERIOD/LEN; zero otherwise.
REQ-009 SHALL have ports led_we (1), led_addr (32), led_din (32), outputs, drive the LED register (fixed address 0xFFFF_0010).

Function
REQ-010 Register map: CTRL 0xFFFF_0020 (W: bit0 START, bit1 LOOP, bit2 STOP); PERIOD 0xFFFF_0024 (CNT_W bits); LEN 0xFFFF_0028 (steps); STATUS 0xFFFF_002C (R: bit0 busy, bits[10:8] idx); PAT[i] 0xFFFF_0030+4i (din[7:0]).
REQ-011 PERIOD=0 SHALL behave as 1; LEN=0 or LEN>NUM_PAT SHALL clamp to 1 and NUM_PAT respectively, evaluated at START.
REQ-012 States: IDLE, LOAD, HOLD, DONE.
REQ-013 IDLE: START write -> LOAD next cycle, idx=0, LOOP bit latched; START while not IDLE ignored.
REQ-014 LOAD: assert led_we=1, led_addr=0xFFFF_0010, led_din={24'b0,PAT[idx]} for exactly one granted cycle -> HOLD, counter cleared.
REQ-015 HOLD: counter increments each cycle; at count==PERIOD-1: if idx==LEN-1 and LOOP=0 -> DONE; else idx = (idx==LEN-1)?0:idx+1 -> LOAD.
REQ-016 DONE: one cycle, then IDLE; led value left at last pattern.
REQ-017 Arbitration: CPU store to 0xFFFF_0010 SHALL pass through to led_* same cycle and win; a coinciding LOAD SHALL stall in LOAD (counter frozen) until the next non-conflicting cycle.
REQ-018 STOP write in any state SHALL force IDLE next cycle; no led_we issued in that cycle or after; STOP+START same write: STOP wins.
REQ-019 PAT/PERIOD/LEN writes while busy SHALL take effect at the next LOAD/HOLD evaluation (PAT, PERIOD) or next START (LEN).
REQ-020 Step-to-step LED update interval SHALL be exactly PERIOD+1 cycles when uncontended.

Reset
REQ-021 rstn low SHALL immediately set state IDLE, idx 0, counter 0, PERIOD 1, LEN 1, PAT all 0, LOOP 0, led_we 0, led_addr 0, led_din 0, dout 0.
REQ-022 Reset mid-sequence SHALL abort with no further led_we after rstn deasserts until a new START.

Configuration
REQ-023 Macro LED_SEQ_IRQ_EN defined: output port irq (1 bit) pulses high for the DONE cycle and on each loop wrap; STATUS bit1 sticky done flag, cleared by CTRL write with bit3 set.
REQ-024 Macro undefined: no irq port, STATUS bit1 reads 0, bit3 of CTRL ignored.

Structure
REQ-025 Shared package SHALL hold state enum, register address constants (LED_ADDR, CTRL/PERIOD/LEN/STATUS/PAT base) and CTRL bit positions.
REQ-026 Sub-module led_seq_timer (loadable CNT_W counter, enable, terminal-count flag) is natural; FSM and register file stay in led_seq.

Verification
REQ-027 PAT={0x01,0x02,0x04,0x08}, PERIOD=3, LEN=4, START -> led_we pulses with din 0x01,0x02,0x04,0x08 spaced 4 cycles, then IDLE, busy=0.
REQ-028 LOOP=1, LEN=2 -> 0x01,0x02,0x01,... until STOP; after STOP zero further led_we.
REQ-029 CPU writes 0xAA to 0xFFFF_0010 on the LOAD cycle -> led_din=0xAA that cycle, sequencer pattern issued next cycle.
REQ-030 PERIOD=0, LEN=9 with NUM_PAT=4 -> treated as PERIOD 1, LEN 4; updates every 2 cycles.
REQ-031 rstn asserted during HOLD -> outputs zero asynchronously, no led_we after release.
REQ-032 With LED_SEQ_IRQ_EN: LEN=2, LOOP=0 run -> single irq pulse on DONE, STATUS bit1=1 until CTRL bit3 write.
